// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the sequential Booth multiplier.
//   state_t         controller FSM states (IDLE, STEP, DONE)
//   BOOTH_SUB/ADD   {Q[0],Qm1} pair codes selecting subtract / add of M
//   BOOTH_W_DEFAULT default operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

  localparam int unsigned BOOTH_W_DEFAULT = 4;

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth step.
// Adds or subtracts M into A as selected by {Q[0],Qm1}, then arithmetic-shifts
// {A,Q,Qm1} right by one bit.
//   a        [W:0]    partial-product high part (W+1 bits)
//   q        [W-1:0]  multiplier / low product bits
//   qm1               previously shifted-out multiplier bit
//   m        [W:0]    sign-extended multiplicand
//   a_next, q_next, qm1_next   register values after the step
module booth_step
  import booth_pkg::*;
#(
  parameter int W = BOOTH_W_DEFAULT
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic         qm1,
  input  logic [W:0]   m,
  output logic [W:0]   a_next,
  output logic [W-1:0] q_next,
  output logic         qm1_next
);

  logic [W:0] sum;

  always_comb begin
    sum = a;
    unique case ({q[0], qm1})
      BOOTH_SUB: sum = a - m;
      BOOTH_ADD: sum = a + m;
      default:   sum = a;
    endcase
  end

  // Arithmetic shift of the concatenation {sum, q, qm1}.
  assign a_next   = {sum[W], sum[W:1]};
  assign q_next   = {sum[0], q[W-1:1]};
  assign qm1_next = q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: multi-cycle radix-2 Booth signed multiplier sequencer.
// Accepts an operand pair on a valid/ready handshake, performs one Booth step
// per clock through a single booth_step datapath, and presents the 2W-bit
// signed product on a valid/ready handshake.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   m, q      [W-1:0]     signed multiplicand / multiplier, sampled on accept
//   out_valid / out_ready product handshake (out_valid high only in DONE)
//   p         [2W-1:0]    signed product m*q, zero outside DONE
//   busy                  high in STEP or DONE
// Optional macro BOOTH_EARLY_TERM_EN: finish in one cycle once the remaining
// multiplier bits and Qm1 are all equal (no further adds needed).
module booth_seq_ctrl #(
  parameter int W = booth_pkg::BOOTH_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     m,
  input  logic [W-1:0]     q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic             busy
);
  import booth_pkg::*;

  localparam int CW = $clog2(W + 1);

  state_t         state_r, state_n;
  logic [W:0]     a_r, a_n;
  logic [W:0]     m_r, m_n;
  logic [W-1:0]   q_r, q_n;
  logic           qm1_r, qm1_n;
  logic [CW-1:0]  cnt_r, cnt_n;

  logic [W:0]     st_a;
  logic [W-1:0]   st_q;
  logic           st_qm1;

  booth_step #(.W(W)) u_step (
    .a        (a_r),
    .q        (q_r),
    .qm1      (qm1_r),
    .m        (m_r),
    .a_next   (st_a),
    .q_next   (st_q),
    .qm1_next (st_qm1)
  );

`ifdef BOOTH_EARLY_TERM_EN
  // The low cnt_r bits of Q are the ones not yet examined; if they all match
  // Qm1, every remaining step is a pure shift and can be collapsed.
  logic                uniform;
  logic signed [2*W:0] ext_sh;

  always_comb begin
    uniform = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (i < 32'(cnt_r) && q_r[i] != qm1_r) uniform = 1'b0;
    end
  end

  assign ext_sh = $signed({a_r, q_r}) >>> cnt_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      m_r     <= '0;
      q_r     <= '0;
      qm1_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      a_r     <= a_n;
      m_r     <= m_n;
      q_r     <= q_n;
      qm1_r   <= qm1_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    a_n     = a_r;
    m_n     = m_r;
    q_n     = q_r;
    qm1_n   = qm1_r;
    cnt_n   = cnt_r;
    unique case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_n     = '0;
          m_n     = {m[W-1], m};
          q_n     = q;
          qm1_n   = 1'b0;
          cnt_n   = CW'(W);
          state_n = STEP;
        end
      end
      STEP: begin
`ifdef BOOTH_EARLY_TERM_EN
        if (uniform) begin
          // Qm1 already equals the bits shifted past it, so it is left as is.
          a_n     = ext_sh[2*W:W];
          q_n     = ext_sh[W-1:0];
          cnt_n   = '0;
          state_n = DONE;
        end else begin
`else
        begin
`endif
          a_n   = st_a;
          q_n   = st_q;
          qm1_n = st_qm1;
          cnt_n = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign p         = (state_r == DONE) ? {a_r[W-1:0], q_r} : '0;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

  localparam int W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] m_in = '0;
  logic signed [W-1:0] q_in = '0;
  logic                out_valid;
  logic                out_ready;
  logic [2*W-1:0]      p;
  logic                busy;

  logic dir_ready = 1'b0;
  logic rnd_ready = 1'b0;
  logic rnd_bit   = 1'b0;
  assign out_ready = rnd_ready ? rnd_bit : dir_ready;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [2*W-1:0] sbq[$];

  booth_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m         (m_in),
    .q         (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed multiplication, queued per accepted pair.
  always @(negedge clk) begin
    logic signed [2*W-1:0] prod;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (in_valid && in_ready) begin
        prod = m_in * q_in;
        sbq.push_back(prod);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) check("unexpected_output", 1, 0);
        else check("scoreboard_p", p, sbq.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_bit = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Caller guarantees the DUT is IDLE; lat counts edges from the presentation
  // edge until out_valid is observed.
  task automatic mul(input logic signed [W-1:0] mm, input logic signed [W-1:0] qq,
                     output logic [2*W-1:0] pr, output int lat);
    m_in = mm; q_in = qq; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      step();
      lat++;
    end
    check("mul_done", out_valid, 1'b1);
    pr = p;
    dir_ready = 1'b1;
    step();
    dir_ready = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] pr;
    int lat;
    int c;
    int base;
    logic rb;

    // Reset
    rst_n = 1'b0;
    step(); step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_p", p, 8'h00);
    rst_n = 1'b1;
    step();

    // Directed products and latency
    mul(3, -2, pr, lat);
    check("p_3x-2", pr, 8'hFA);
`ifdef BOOTH_EARLY_TERM_EN
    check("lat_3x-2_bound", lat <= W + 1, 1'b1);
`else
    check("lat_3x-2", lat, W + 1);
`endif
    mul(-8, -8, pr, lat);
    check("p_-8x-8", pr, 8'h40);
    mul(-8, 7, pr, lat);
    check("p_-8x7", pr, 8'hC8);
    mul(7, -8, pr, lat);
    check("p_7x-8", pr, 8'hC8);

    // Short-circuit candidates: product must not depend on the build
    mul(5, 0, pr, lat);
    check("p_q0", pr, 8'h00);
`ifdef BOOTH_EARLY_TERM_EN
    check("lat_q0", lat, 2);
`else
    check("lat_q0", lat, W + 1);
`endif
    mul(6, -1, pr, lat);
    check("p_6x-1", pr, 8'hFA);
    check("lat_6x-1_bound", lat <= W + 1, 1'b1);

    // Exhaustive pairs with random gaps and random consumer stalls
    base = n_out;
    rnd_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      m_in = pair[7:4];
      q_in = pair[3:0];
      in_valid = 1'b1;
      c = 0;
      do begin
        rb = in_ready;
        step();
        c++;
      end while (!rb && c < 200);
      if (!rb) check("accept_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    c = 0;
    while (sbq.size() != 0 && c < 200) begin
      step();
      c++;
    end
    rnd_ready = 1'b0;
    step(); step();
    check("exh_drained", sbq.size(), 0);
    check("exh_count", n_out - base, 256);
    check("exh_idle", in_ready, 1'b1);

    // Backpressure in DONE with the next operands already offered
    m_in = 2; q_in = 3; in_valid = 1'b1;
    step();
    m_in = -3; q_in = 5;
    c = 0;
    while (!out_valid && c < 60) begin
      check("bp_held_off", in_ready, 1'b0);
      step();
      c++;
    end
    check("bp_done", out_valid, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("bp_p_stable", p, 8'h06);
      check("bp_valid_stable", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    dir_ready = 1'b1;
    step();
    dir_ready = 1'b0;
    check("bp_released_valid", out_valid, 1'b0);
    check("bp_released_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_next_accepted", busy, 1'b1);
    c = 0;
    while (!out_valid && c < 60) begin
      step();
      c++;
    end
    check("bp_next_p", p, 8'hF1);
    dir_ready = 1'b1;
    step();
    dir_ready = 1'b0;
    step();

    // Asynchronous reset during the second STEP cycle
    m_in = 3; q_in = 3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("rst_mid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_in_ready", in_ready, 1'b1);
    check("rstmid_out_valid", out_valid, 1'b0);
    check("rstmid_p", p, 8'h00);
    check("rstmid_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    mul(5, 5, pr, lat);
    check("p_after_reset", pr, 8'h19);

    // out_ready outside DONE is ignored
    dir_ready = 1'b1;
    step();
    check("stray_ready_idle", in_ready, 1'b1);
    dir_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
